// File: rtl/fft_pkg.sv
// Shared types and helpers for the 8-point FFT front end.
// Sample layout: [31:16] real, [15:0] imaginary, two's complement.
package fft_pkg;

  localparam int CPX_W = 32;
  localparam int N_PTS = 8;
  localparam int LOG2N = 3;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cpx_t;

  typedef enum logic {
    LOAD,
    ISSUE
  } state_t;

  function automatic logic [2:0] bitrev3(
    input logic [2:0] v
  );
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/fft_input_reorder.sv
// Bit-reversal input buffer feeding stage-1 radix-2 butterfly pairs.
// Optional FFT_INPUT_SCALE_EN halves re/im on store for headroom.
module fft_input_reorder #(
  parameter int CPX_W = 32,
  parameter int N_PTS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CPX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [CPX_W-1:0] out_num1,
  output logic [CPX_W-1:0] out_num2,
  output logic [2:0]       out_twiddle_index,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  import fft_pkg::*;

  state_t     state_q, state_d;
  logic [2:0] ld_cnt_q, ld_cnt_d;
  logic [1:0] pr_cnt_q, pr_cnt_d;
  cpx_t       num1_q, num1_d;
  cpx_t       num2_q, num2_d;
  cpx_t       mem_q [8];
  cpx_t       smp;
  logic       in_fire;

  always_comb begin
    smp = cpx_t'(in_data[31:0]);
`ifdef FFT_INPUT_SCALE_EN
    smp.re = smp.re >>> 1;
    smp.im = smp.im >>> 1;
`endif
  end

  assign in_fire = (state_q == LOAD) && in_valid;

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    pr_cnt_d = pr_cnt_q;
    num1_d   = num1_q;
    num2_d   = num2_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          ld_cnt_d = ld_cnt_q + 3'd1;
          // Pair 0 lives in slots 0/1, never the 8th sample's slot.
          if (ld_cnt_q == 3'd7) begin
            state_d = ISSUE;
            num1_d  = mem_q[0];
            num2_d  = mem_q[1];
          end
        end
      end
      ISSUE: begin
        if (out_ready) begin
          pr_cnt_d = pr_cnt_q + 2'd1;
          if (pr_cnt_q == 2'd3) begin
            state_d = LOAD;
          end else begin
            num1_d = mem_q[{pr_cnt_d, 1'b0}];
            num2_d = mem_q[{pr_cnt_d, 1'b1}];
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD;
      ld_cnt_q <= '0;
      pr_cnt_q <= '0;
      num1_q   <= '0;
      num2_q   <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      pr_cnt_q <= pr_cnt_d;
      num1_q   <= num1_d;
      num2_q   <= num2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[bitrev3(ld_cnt_q)] <= smp;
    end
  end

  assign in_ready          = (state_q == LOAD);
  assign out_valid         = (state_q == ISSUE);
  assign busy              = (state_q == ISSUE);
  assign out_last          = (state_q == ISSUE) && (pr_cnt_q == 2'd3);
  assign out_twiddle_index = 3'd0;
  assign out_num1          = CPX_W'(num1_q);
  assign out_num2          = CPX_W'(num2_q);

endmodule

// File: tb/tb_fft_input_reorder.sv
// Randomized bench for fft_input_reorder against a frame-level model.
module tb_fft_input_reorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_num1, out_num2;
  logic [2:0]  out_twiddle_index;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;

  fft_input_reorder dut (
    .clk               (clk),
    .rst               (rst),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .out_num1          (out_num1),
    .out_num2          (out_num2),
    .out_twiddle_index (out_twiddle_index),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        last;
  } pair_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] frame[$];
  logic [31:0] fixed[$];
  pair_t       expq[$];
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [31:0] prev_n1 = '0;
  logic [31:0] prev_n2 = '0;
  int          first_idx[4] = '{0, 2, 1, 3};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] stored(logic [31:0] x);
    shortint re, im;
    re = shortint'(x[31:16]);
    im = shortint'(x[15:0]);
`ifdef FFT_INPUT_SCALE_EN
    re = re >>> 1;
    im = im >>> 1;
`endif
    return {re, im};
  endfunction

  function automatic logic [31:0] gen();
    if (fixed.size() != 0) return fixed.pop_front();
    return $urandom;
  endfunction

  // Stage-1 DIT pairs x[k], x[k+4] in bit-reversed k order.
  task automatic push_frame();
    pair_t p;
    for (int k = 0; k < 4; k++) begin
      p.a    = frame[first_idx[k]];
      p.b    = frame[first_idx[k] + 4];
      p.last = (k == 3);
      expq.push_back(p);
    end
    frame.delete();
  endtask

  task automatic step(int pv, int pr);
    logic inf, outf;
    pair_t p;
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(expq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(expq.size() == 0));
    chk("busy", 32'(busy), 32'(expq.size() != 0));
    if (out_valid) begin
      chk("twiddle", 32'(out_twiddle_index), 32'd0);
      if (prev_v && !prev_r) begin
        chk("hold_n1", out_num1, prev_n1);
        chk("hold_n2", out_num2, prev_n2);
      end
    end else begin
      chk("last_idle", 32'(out_last), 32'd0);
    end
    outf = out_valid && out_ready;
    inf  = in_valid && in_ready;
    if (out_valid && expq.size() != 0) begin
      p = expq[0];
      chk("num1", out_num1, p.a);
      chk("num2", out_num2, p.b);
      chk("last", 32'(out_last), 32'(p.last));
      if (outf) void'(expq.pop_front());
    end
    if (inf) begin
      frame.push_back(stored(in_data));
      if (frame.size() == 8) push_frame();
    end
    prev_v  = out_valid;
    prev_r  = out_ready;
    prev_n1 = out_num1;
    prev_n2 = out_num2;
    @(posedge clk);
    #1;
    if (!in_valid || inf) begin
      in_valid = ($urandom % 100) < pv;
      in_data  = gen();
    end
    out_ready = ($urandom % 100) < pr;
  endtask

  task automatic chk_reset_state(string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    chk({tag, "_n1"}, out_num1, 32'd0);
    chk({tag, "_n2"}, out_num2, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Two back-to-back frames: ramp, then one with a scale probe.
    for (int n = 0; n < 8; n++) fixed.push_back(32'(n) * 32'h0001_0001);
    fixed.push_back(32'h8001_0003);
    for (int n = 1; n < 8; n++) fixed.push_back(32'h0000_0200 + 32'(n));
    repeat (40) step(100, 100);

    // Backpressure on pairs with a bursty producer.
    repeat (300) step(70, 30);
    repeat (300) step(40, 80);
    repeat (40) step(0, 100);

    // Drop a partial frame, then reload a known one.
    for (int i = 0; i < 100 && frame.size() != 5; i++) step(100, 100);
    chk("partial5", 32'(frame.size()), 32'd5);
    rst = 1'b1;
    in_valid = 1'b0;
    frame.delete();
    expq.delete();
    prev_v = 1'b0;
    @(negedge clk);
    chk_reset_state("mid");
    rst = 1'b0;
    for (int n = 0; n < 8; n++) fixed.push_back(32'h100 + 32'(n));
    @(posedge clk);
    #1;
    repeat (30) step(100, 100);

    // Reset while a frame is draining.
    for (int i = 0; i < 100 && expq.size() != 2; i++) step(100, 100);
    chk("issue_seen", 32'(expq.size()), 32'd2);
    rst = 1'b1;
    in_valid = 1'b0;
    frame.delete();
    expq.delete();
    prev_v = 1'b0;
    @(negedge clk);
    chk_reset_state("iss");
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (400) step(60, 60);
    repeat (40) step(0, 100);
    chk("drained", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
